vga_mem_arbiter: RTL and testbench



---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_rd_tagpipe.sv | 43 ++++
 rtl/vga_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_pkg : fetch FSM states, writer slot period, 800x600 constants |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int WR_SLOT_PERIOD = 8;

  localparam int H_ACTIVE    = 800;
  localparam int H_TOTAL     = 1056;
  localparam int V_ACTIVE    = 600;
  localparam int V_TOTAL     = 628;
  localparam int PX_PER_WORD = 16;

  localparam int DEF_LINE_WORDS = H_ACTIVE / PX_PER_WORD;
  localparam int DEF_V_LINES    = V_ACTIVE;

endpackage
`default_nettype wire

// File: rtl/vga_rd_tagpipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_rd_tagpipe : valid/index shift register matching read latency |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vga_rd_tagpipe
  import vga_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] r_valid;
  logic [IDX_W-1:0] r_idx [DEPTH];

  // Flush drops in-flight tags but still accepts the read issued this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_idx[i] <= '0;
    end else begin
      r_valid[0] <= in_valid;
      r_idx[0]   <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1] & ~flush;
        r_idx[i]   <= r_idx[i-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_idx   = r_idx[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_mem_arbiter : line fetch (priority) + writer sharing one RAM  |
// | Option macro WRITER_SLOT_EN opens writer slots during FETCH.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int V_LINES    = DEF_V_LINES,
  parameter int MEM_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_req,
  input  logic [9:0]        line_num,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              fetch_busy,
  output logic              underrun,
  output logic              lb_we,
  output logic [5:0]        lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = 6;
  localparam int RUN_W = $clog2(WR_SLOT_PERIOD + 1);
`ifdef WRITER_SLOT_EN
  localparam bit SLOT_EN = 1'b1;
`else
  localparam bit SLOT_EN = 1'b0;
`endif

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_line_addr;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [RUN_W-1:0]  r_run_cnt;
  logic              r_fetch_busy, r_underrun, r_lb_we, r_wr_ack, r_mem_re, r_mem_we;
  logic [CNT_W-1:0]  r_lb_addr;
  logic [DATA_W-1:0] r_lb_wdata, r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;

  logic              w_line_ok, w_start, w_busy, w_more, w_wr_elig, w_slot;
  logic              w_fetch_rd, w_rd_issue, w_wr_grant, w_tag_valid, w_lb_load;
  logic [ADDR_W-1:0] w_line_addr, w_rd_addr;
  logic [CNT_W-1:0]  w_rd_idx, w_tag_idx;

  assign w_line_ok   = int'(line_num) < V_LINES;
  assign w_line_addr = frame_base + ADDR_W'(int'(line_num) * LINE_WORDS);
  assign w_start     = line_req && w_line_ok;
  assign w_busy      = (r_state != IDLE);
  assign w_more      = int'(r_issue_cnt) < LINE_WORDS;
  assign w_wr_elig   = wr_req && !r_wr_ack;
  assign w_slot      = SLOT_EN && (r_state == FETCH) && w_more &&
                       (int'(r_run_cnt) == WR_SLOT_PERIOD) && w_wr_elig;
  assign w_fetch_rd  = !line_req && (r_state == FETCH) && w_more && !w_slot;
  assign w_rd_issue  = w_start || w_fetch_rd;
  assign w_rd_addr   = w_start ? w_line_addr : r_line_addr + ADDR_W'(r_issue_cnt);
  assign w_rd_idx    = w_start ? '0 : r_issue_cnt;
  assign w_wr_grant  = w_wr_elig && !w_rd_issue;
  // A new request discards whatever return is surfacing this cycle.
  assign w_lb_load   = w_tag_valid && !line_req;

  vga_rd_tagpipe #(
    .DEPTH (MEM_LAT),
    .IDX_W (CNT_W)
  ) u_tagpipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (line_req),
    .in_valid  (w_rd_issue),
    .in_idx    (w_rd_idx),
    .out_valid (w_tag_valid),
    .out_idx   (w_tag_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_line_addr  <= '0;
      r_issue_cnt  <= '0;
      r_run_cnt    <= '0;
      r_fetch_busy <= 1'b0;
      r_underrun   <= 1'b0;
      r_lb_we      <= 1'b0;
      r_lb_addr    <= '0;
      r_lb_wdata   <= '0;
      r_wr_ack     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_mem_re    <= w_rd_issue;
      r_mem_we    <= w_wr_grant;
      r_wr_ack    <= w_wr_grant;
      r_mem_addr  <= w_rd_issue ? w_rd_addr : (w_wr_grant ? wr_addr : '0);
      r_mem_wdata <= w_wr_grant ? wr_data : '0;
      r_underrun  <= line_req && w_busy;
      r_lb_we     <= w_lb_load;
      if (w_lb_load) begin
        r_lb_addr  <= w_tag_idx;
        r_lb_wdata <= mem_rdata;
      end

      if (line_req) begin
        if (w_line_ok) begin
          r_state      <= FETCH;
          r_line_addr  <= w_line_addr;
          r_issue_cnt  <= CNT_W'(1);
          r_run_cnt    <= RUN_W'(1);
          r_fetch_busy <= 1'b1;
        end else begin
          r_state      <= IDLE;
          r_fetch_busy <= 1'b0;
        end
      end else begin
        case (r_state)
          FETCH: begin
            if (!w_more) begin
              r_state <= DRAIN;
            end else if (w_slot) begin
              r_run_cnt <= '0;
            end else begin
              r_issue_cnt <= r_issue_cnt + CNT_W'(1);
              r_run_cnt   <= (int'(r_run_cnt) == WR_SLOT_PERIOD) ? RUN_W'(1)
                                                                  : r_run_cnt + RUN_W'(1);
            end
          end
          DRAIN: begin
            // Returns arrive in index order, so the last index ends the line.
            if (r_lb_we && int'(r_lb_addr) == LINE_WORDS - 1) begin
              r_state      <= IDLE;
              r_fetch_busy <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign fetch_busy = r_fetch_busy;
  assign underrun   = r_underrun;
  assign lb_we      = r_lb_we;
  assign lb_addr    = r_lb_addr;
  assign lb_wdata   = r_lb_wdata;
  assign wr_ack     = r_wr_ack;
  assign mem_addr   = r_mem_addr;
  assign mem_re     = r_mem_re;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vga_mem_arbiter : directed bench for vga_mem_arbiter           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_vga_mem_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
`ifdef WRITER_SLOT_EN
  localparam int EXP_ACKS    = 9;
  localparam int EXP_ACK1    = 9;
  localparam int EXP_LB_LAST = 58;
`else
  localparam int EXP_ACKS    = 6;
  localparam int EXP_ACK1    = 51;
  localparam int EXP_LB_LAST = 52;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              line_req = 1'b0;
  logic [9:0]        line_num = '0;
  logic [ADDR_W-1:0] frame_base = '0;
  logic              fetch_busy, underrun, lb_we, wr_ack, mem_re, mem_we;
  logic [5:0]        lb_addr;
  logic [DATA_W-1:0] lb_wdata, mem_wdata;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;

  vga_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(50), .V_LINES(600), .MEM_LAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .line_req(line_req), .line_num(line_num),
    .frame_base(frame_base), .fetch_busy(fetch_busy), .underrun(underrun),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_fn(input logic [18:0] a);
    return a[15:0] ^ 16'hA5A5 ^ {13'd0, a[18:16]};
  endfunction

  // Synchronous RAM: data registered on the edge that samples mem_re.
  always @(posedge clk) if (mem_re) mem_rdata <= rd_fn(mem_addr);

  int n_chk = 0;
  int n_err = 0;
  int re_n, re_first, bad_re, lb_n, lb_last, bad_lb, busy_n, busy_last;
  int und_n, und_first, ack_n, ack_first, bad_wr;
  logic [ADDR_W-1:0] exp_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic reset_stats();
    re_n = 0; re_first = 0; bad_re = 0; lb_n = 0; lb_last = 0; bad_lb = 0;
    busy_n = 0; busy_last = 0; und_n = 0; und_first = 0;
    ack_n = 0; ack_first = 0; bad_wr = 0;
  endtask

  task automatic pulse_line(input logic [ADDR_W-1:0] b, input logic [9:0] num);
    frame_base = b;
    line_num   = num;
    line_req   = 1'b1;
  endtask

  // Cycle k counts from 1 = the cycle after the current one.
  task automatic observe(input int ncyc);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      line_req = 1'b0;
      if (mem_re) begin
        if (re_n == 0) re_first = k;
        if (mem_addr !== exp_base + 19'(re_n)) bad_re++;
        re_n++;
      end
      if (lb_we) begin
        if (lb_addr !== 6'(lb_n) || lb_wdata !== rd_fn(exp_base + 19'(lb_n))) bad_lb++;
        lb_n++;
        lb_last = k;
      end
      if (fetch_busy) begin busy_n++; busy_last = k; end
      if (underrun) begin
        if (und_n == 0) und_first = k;
        und_n++;
      end
      if (wr_ack) begin
        if (ack_n == 0) ack_first = k;
        ack_n++;
        if (!mem_we || mem_re || mem_addr !== wr_addr || mem_wdata !== wr_data) bad_wr++;
        wr_addr = wr_addr + 19'd1;
        wr_data = wr_data + 16'd1;
      end else if (mem_we) begin
        bad_wr++;
      end
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [9:0]        num;
    logic [ADDR_W-1:0] exp_addr;
    int                exp_reads;
    int                exp_first;
    int                exp_lb_last;
    int                exp_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{19'h00100, 10'd3,    19'h00196, 50, 1, 52, 52};
    vecs[1] = '{19'h7FFF0, 10'd599,  19'h074EE, 50, 1, 52, 52};
    vecs[2] = '{19'h12345, 10'd0,    19'h12345, 50, 1, 52, 52};
    vecs[3] = '{19'h00000, 10'd600,  19'h00000, 0,  0, 0,  0};
    vecs[4] = '{19'h00000, 10'd1023, 19'h00000, 0,  0, 0,  0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({fetch_busy, underrun, lb_we, wr_ack, mem_re, mem_we}), 32'd0);
    chk("reset_bus", 32'(mem_addr) | 32'(mem_wdata) | 32'(lb_wdata) | 32'(lb_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      reset_stats();
      exp_base = vecs[v].exp_addr;
      pulse_line(vecs[v].base, vecs[v].num);
      observe(60);
      chk($sformatf("v%0d_reads", v),     re_n,      vecs[v].exp_reads);
      chk($sformatf("v%0d_re_first", v),  re_first,  vecs[v].exp_first);
      chk($sformatf("v%0d_re_addr", v),   bad_re,    0);
      chk($sformatf("v%0d_lb_count", v),  lb_n,      vecs[v].exp_reads);
      chk($sformatf("v%0d_lb_last", v),   lb_last,   vecs[v].exp_lb_last);
      chk($sformatf("v%0d_lb_data", v),   bad_lb,    0);
      chk($sformatf("v%0d_busy_n", v),    busy_n,    vecs[v].exp_busy);
      chk($sformatf("v%0d_busy_last", v), busy_last, vecs[v].exp_busy);
      chk($sformatf("v%0d_underrun", v),  und_n,     0);
    end

    // Held write request in IDLE: granted next cycle, then every other cycle.
    wr_addr = 19'h0ABCD;
    wr_data = 16'h1234;
    wr_req  = 1'b1;
    @(negedge clk);
    chk("idle_ack", 32'(wr_ack), 32'd1);
    chk("idle_we", 32'(mem_we), 32'd1);
    chk("idle_addr", 32'(mem_addr), 32'h0ABCD);
    chk("idle_wdata", 32'(mem_wdata), 32'h1234);
    @(negedge clk);
    chk("idle_no_double", 32'(wr_ack), 32'd0);
    @(negedge clk);
    chk("idle_reack", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
    repeat (3) @(negedge clk);

    // Writer held across a whole fetch.
    reset_stats();
    exp_base = 19'h00196;
    wr_addr  = 19'h40000;
    wr_data  = 16'hBEE0;
    wr_req   = 1'b1;
    pulse_line(19'h00100, 10'd3);
    observe(62);
    wr_req = 1'b0;
    chk("held_acks", ack_n, EXP_ACKS);
    chk("held_ack_first", ack_first, EXP_ACK1);
    chk("held_wr_fields", bad_wr, 0);
    chk("held_reads", re_n, 50);
    chk("held_re_addr", bad_re, 0);
    chk("held_lb_count", lb_n, 50);
    chk("held_lb_last", lb_last, EXP_LB_LAST);
    chk("held_lb_data", bad_lb, 0);
    repeat (3) @(negedge clk);

    // Underrun: second valid request 20 cycles into a fetch.
    reset_stats();
    exp_base = 19'h00196;
    pulse_line(19'h00100, 10'd3);
    observe(20);
    chk("ur_old_lb_count", lb_n, 18);
    chk("ur_old_lb_data", bad_lb, 0);
    chk("ur_old_underrun", und_n, 0);
    reset_stats();
    exp_base = 19'h021F4;
    pulse_line(19'h02000, 10'd10);
    observe(60);
    chk("ur_pulses", und_n, 1);
    chk("ur_pulse_cycle", und_first, 1);
    chk("ur_reads", re_n, 50);
    chk("ur_re_first", re_first, 1);
    chk("ur_re_addr", bad_re, 0);
    chk("ur_lb_count", lb_n, 50);
    chk("ur_lb_last", lb_last, 52);
    chk("ur_lb_data", bad_lb, 0);
    chk("ur_busy_last", busy_last, 52);

    // Underrun by an out-of-range line aborts to IDLE.
    reset_stats();
    exp_base = 19'h00196;
    pulse_line(19'h00100, 10'd3);
    observe(5);
    reset_stats();
    exp_base = 19'h00000;
    pulse_line(19'h00000, 10'd700);
    observe(10);
    chk("abort_underrun", und_n, 1);
    chk("abort_reads", re_n, 0);
    chk("abort_lb", lb_n, 0);
    chk("abort_busy", busy_n, 0);

    // Asynchronous reset in the middle of a fetch.
    reset_stats();
    exp_base = 19'h00196;
    pulse_line(19'h00100, 10'd3);
    observe(10);
    chk("rst_pre_re", 32'(mem_re), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", 32'({fetch_busy, underrun, lb_we, wr_ack, mem_re, mem_we}), 32'd0);
    chk("rst_async_bus", 32'(mem_addr) | 32'(mem_wdata) | 32'(lb_wdata) | 32'(lb_addr), 32'd0);
    wr_addr = 19'h05555;
    wr_data = 16'h7777;
    wr_req  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_post_ack", 32'(wr_ack), 32'd1);
    chk("rst_post_addr", 32'(mem_addr), 32'h05555);
    chk("rst_post_idle", 32'({fetch_busy, mem_re}), 32'd0);
    wr_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
